// File: rtl/gpr_mp.sv
// Multi-port general purpose register file with per-byte writes, same-cycle
// write-to-read bypass, optional hard-wired zero register and busy scoreboard.
module gpr_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_RD*ADDR_W-1:0]       rd_addr,
    output logic [NUM_RD*DATA_W-1:0]       rd_data,
    output logic [NUM_RD-1:0]              rd_busy,
    input  logic [NUM_WR-1:0]              we_,
    input  logic [NUM_WR*ADDR_W-1:0]       wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]       wr_data,
    input  logic [NUM_WR*(DATA_W/8)-1:0]   wr_be,
    input  logic [NUM_WR-1:0]              wr_clr,
    input  logic                           sb_set_,
    input  logic [ADDR_W-1:0]              sb_addr
);
    localparam int REG_NUM = 2**ADDR_W;
    localparam int NB      = DATA_W / 8;

    logic [DATA_W-1:0]  r_regs [REG_NUM];
    logic [REG_NUM-1:0] r_busy;
    logic [REG_NUM-1:0] w_busy_set;
    logic [REG_NUM-1:0] w_busy_clr;
    logic [REG_NUM-1:0] w_busy_nxt;

    // Ports are visited in ascending order so the highest-index port wins a shared byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < REG_NUM; r++) begin
                r_regs[r] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int r = 0; r < REG_NUM; r++) begin
                if (!(ZERO_REG != 0 && r == 0)) begin
                    for (int j = 0; j < NUM_WR; j++) begin
                        for (int b = 0; b < NB; b++) begin
                            if (!we_[j] && wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(r)
                                && wr_be[j*NB + b]) begin
                                r_regs[r][b*8 +: 8] <= wr_data[j*DATA_W + b*8 +: 8];
                            end
                        end
                    end
                end
            end
            r_busy <= w_busy_nxt;
        end
    end

    always_comb begin
        w_busy_set = '0;
        w_busy_clr = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            if (!we_[j] && wr_clr[j]) begin
                w_busy_clr[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
        if (!sb_set_) begin
            w_busy_set[sb_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            w_busy_set[0] = 1'b0;
        end
    end

    // A new producer issued in the same cycle as a clearing write keeps the register busy.
    assign w_busy_nxt = w_busy_set | (r_busy & ~w_busy_clr);

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_data[k*DATA_W +: DATA_W] = r_regs[rd_addr[k*ADDR_W +: ADDR_W]];
            rd_busy[k]                  = r_busy[rd_addr[k*ADDR_W +: ADDR_W]];
            if (BYPASS != 0) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (!we_[j] && wr_addr[j*ADDR_W +: ADDR_W] == rd_addr[k*ADDR_W +: ADDR_W]) begin
                        for (int b = 0; b < NB; b++) begin
                            if (wr_be[j*NB + b]) begin
                                rd_data[k*DATA_W + b*8 +: 8] = wr_data[j*DATA_W + b*8 +: 8];
                            end
                        end
                        if (wr_clr[j]) begin
                            rd_busy[k] = 1'b0;
                        end
                    end
                end
            end
            if (ZERO_REG != 0 && rd_addr[k*ADDR_W +: ADDR_W] == '0) begin
                rd_data[k*DATA_W +: DATA_W] = '0;
                rd_busy[k]                  = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gpr_mp.sv
// Directed bench for gpr_mp: one bypassing and one non-bypassing instance,
// both with four read ports, driven from the same write/scoreboard inputs.
module tb_gpr_mp;
    logic         clk;
    logic         reset;
    logic [19:0]  rd_addr;
    logic [127:0] rd_data;
    logic [127:0] nb_rd_data;
    logic [3:0]   rd_busy;
    logic [3:0]   nb_rd_busy;
    logic [1:0]   we_;
    logic [9:0]   wr_addr;
    logic [63:0]  wr_data;
    logic [7:0]   wr_be;
    logic [1:0]   wr_clr;
    logic         sb_set_;
    logic [4:0]   sb_addr;

    int vectors;
    int miscompares;

    gpr_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)) u_byp (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .we_(we_), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .wr_clr(wr_clr),
        .sb_set_(sb_set_), .sb_addr(sb_addr)
    );

    gpr_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .NUM_WR(2), .ZERO_REG(1), .BYPASS(0)) u_nb (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
        .we_(we_), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .wr_clr(wr_clr),
        .sb_set_(sb_set_), .sb_addr(sb_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bd(input int k);
        return rd_data[k*32 +: 32];
    endfunction

    function automatic logic [31:0] nd(input int k);
        return nb_rd_data[k*32 +: 32];
    endfunction

    task automatic idle();
        we_     = 2'b11;
        wr_addr = '0;
        wr_data = '0;
        wr_be   = '0;
        wr_clr  = '0;
        sb_set_ = 1'b1;
        sb_addr = '0;
    endtask

    task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1,
                          input logic [4:0] a2, input logic [4:0] a3);
        rd_addr = {a3, a2, a1, a0};
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic clr);
        we_[p]             = 1'b0;
        wr_addr[p*5 +: 5]  = a;
        wr_data[p*32 +: 32] = d;
        wr_be[p*4 +: 4]    = be;
        wr_clr[p]          = clr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        idle();
        set_ra(5'd0, 5'd5, 5'd9, 5'd31);
        reset = 1'b0;
        #3;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_hold_data%0d", k), bd(k), 32'h0);
            chk($sformatf("rst_hold_nb_data%0d", k), nd(k), 32'h0);
        end
        chk("rst_hold_busy", {28'h0, rd_busy}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        step();

        // Reset asserted while a write to r5 is pending: the write must be lost.
        wr(0, 5'd5, 32'hDEADBEEF, 4'hF, 1'b0);
        #2;
        reset = 1'b0;
        step();
        idle();
        reset = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_rel_data%0d", k), bd(k), 32'h0);
            chk($sformatf("rst_rel_nb_data%0d", k), nd(k), 32'h0);
        end
        chk("rst_rel_busy", {28'h0, rd_busy}, 32'h0);
        chk("rst_rel_nb_busy", {28'h0, nb_rd_busy}, 32'h0);

        // Full-word write with same-cycle bypass.
        set_ra(5'd3, 5'd3, 5'd3, 5'd3);
        wr(0, 5'd3, 32'h12345678, 4'hF, 1'b0);
        #1;
        chk("byp_same_cycle", bd(0), 32'h12345678);
        chk("nb_same_cycle", nd(0), 32'h0);
        step();
        idle();
        #1;
        chk("byp_next_cycle", bd(0), 32'h12345678);
        chk("nb_next_cycle", nd(0), 32'h12345678);

        // Byte-enable merge with port collision on r7.
        set_ra(5'd7, 5'd7, 5'd7, 5'd7);
        wr(0, 5'd7, 32'hAAAAAAAA, 4'hF, 1'b0);
        step();
        wr(0, 5'd7, 32'h11111111, 4'b0011, 1'b0);
        wr(1, 5'd7, 32'h22222222, 4'b0110, 1'b0);
        #1;
        chk("coll_byp", bd(0), 32'hAA222211);
        chk("coll_nb_old", nd(0), 32'hAAAAAAAA);
        step();
        idle();
        #1;
        chk("coll_stored", bd(0), 32'hAA222211);
        chk("coll_nb_stored", nd(0), 32'hAA222211);

        // Zero register ignores writes and scoreboard sets.
        set_ra(5'd7, 5'd0, 5'd7, 5'd7);
        wr(0, 5'd0, 32'hFFFFFFFF, 4'hF, 1'b0);
        sb_set_ = 1'b0;
        sb_addr = 5'd0;
        #1;
        chk("zero_same_data", bd(1), 32'h0);
        chk("zero_same_busy", {31'h0, rd_busy[1]}, 32'h0);
        step();
        idle();
        #1;
        chk("zero_next_data", bd(1), 32'h0);
        chk("zero_next_nb_data", nd(1), 32'h0);
        chk("zero_next_busy", {31'h0, rd_busy[1]}, 32'h0);
        chk("zero_next_nb_busy", {31'h0, nb_rd_busy[1]}, 32'h0);

        // Scoreboard: set, bypassed clear, and set-wins on a same-cycle collision.
        set_ra(5'd9, 5'd9, 5'd9, 5'd9);
        sb_set_ = 1'b0;
        sb_addr = 5'd9;
        #1;
        chk("sb_set_not_fwd", {31'h0, rd_busy[0]}, 32'h0);
        step();
        idle();
        #1;
        chk("sb_set_busy", {31'h0, rd_busy[0]}, 32'h1);
        chk("sb_set_nb_busy", {31'h0, nb_rd_busy[0]}, 32'h1);
        wr(1, 5'd9, 32'h55555555, 4'h0, 1'b1);
        #1;
        chk("sb_clr_byp", {31'h0, rd_busy[0]}, 32'h0);
        chk("sb_clr_nb", {31'h0, nb_rd_busy[0]}, 32'h1);
        chk("sb_clr_no_data", bd(0), 32'h0);
        step();
        idle();
        #1;
        chk("sb_clr_after", {31'h0, rd_busy[0]}, 32'h0);
        chk("sb_clr_nb_after", {31'h0, nb_rd_busy[0]}, 32'h0);
        chk("sb_clr_nb_data", nd(0), 32'h0);
        step();
        wr(0, 5'd9, 32'h0, 4'h0, 1'b1);
        sb_set_ = 1'b0;
        sb_addr = 5'd9;
        step();
        idle();
        #1;
        chk("sb_set_wins", {31'h0, rd_busy[0]}, 32'h1);
        chk("sb_set_wins_nb", {31'h0, nb_rd_busy[0]}, 32'h1);

        // Four read ports on distinct registers.
        wr(0, 5'd1, 32'd1, 4'hF, 1'b0);
        wr(1, 5'd2, 32'd2, 4'hF, 1'b0);
        step();
        wr(0, 5'd3, 32'd3, 4'hF, 1'b0);
        wr(1, 5'd4, 32'd4, 4'hF, 1'b0);
        step();
        idle();
        set_ra(5'd4, 5'd3, 5'd2, 5'd1);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("mp_byp_port%0d", k), bd(k), 32'(4 - k));
            chk($sformatf("mp_nb_port%0d", k), nd(k), 32'(4 - k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
